// File: rtl/sn_pkg.sv
// -----------------------------------------------------------------------------
// sn_pkg
// Shared definitions for the stochastic-number (SN) decoder and the
// encoder-side checkers:
//   - DEF_WIN_LOG2 / DEF_OUT_W : default window length (log2) and output width
//   - sn_out_state_e           : EMPTY/FULL encoding of the output register
//   - sn_scale()               : window total -> binary estimate (shift and
//                                saturate the all-ones window)
// -----------------------------------------------------------------------------
package sn_pkg;

    localparam int DEF_WIN_LOG2 = 8;
    localparam int DEF_OUT_W    = 8;

    // The encoding is chosen so that the state bit is the est_valid flag.
    typedef enum logic {
        SN_EMPTY = 1'b0,
        SN_FULL  = 1'b1
    } sn_out_state_e;

    // A window of 2**win_log2 bits yields totals 0..2**win_log2. The right
    // shift maps that onto OUT_W bits, except the single all-ones total, which
    // would need one extra bit and is clamped to the largest code instead.
    function automatic logic [31:0] sn_scale(input logic [31:0] total,
                                             input int          win_log2,
                                             input int          out_w);
        logic [31:0] full_win;
        full_win = 32'd1 << win_log2;
        if (total == full_win) begin
            sn_scale = (32'd1 << out_w) - 32'd1;
        end else begin
            sn_scale = total >> (win_log2 - out_w);
        end
    endfunction

endpackage

// File: rtl/sn_window_counter.sv
// -----------------------------------------------------------------------------
// sn_window_counter
// Counts valid SN bits and ones over a window of 2**WIN_LOG2 valid bits.
// Ports:
//   clk        in   posedge clock
//   rst_n      in   synchronous reset, active HIGH
//   sn_bit     in   stochastic bit
//   sn_valid   in   sn_bit is sampled this cycle
//   win_clr    in   restart the current window (the bit in this cycle is dropped)
//   win_done_o out  pulse: this cycle carries the last bit of a window
//   total_o    out  ones in the finished window, including the last bit
// -----------------------------------------------------------------------------
module sn_window_counter
    import sn_pkg::*;
#(
    parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sn_bit,
    input  logic                sn_valid,
    input  logic                win_clr,
    output logic                win_done_o,
    output logic [WIN_LOG2:0]   total_o
);

    logic [WIN_LOG2-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIN_LOG2:0]   ones_cnt_q, ones_cnt_d;

    // A clear in the same cycle as the last bit drops that bit, so no window
    // end is reported for it.
    assign win_done_o = sn_valid && !win_clr && (bit_cnt_q == '1);
    assign total_o    = ones_cnt_q + (WIN_LOG2 + 1)'(sn_bit);

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        if (win_clr) begin
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
        end else if (sn_valid) begin
            if (win_done_o) begin
                // Next valid bit is bit 0 of the next window, no stall.
                bit_cnt_d  = '0;
                ones_cnt_d = '0;
            end else begin
                bit_cnt_d  = bit_cnt_q + WIN_LOG2'(1);
                ones_cnt_d = total_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end

endmodule

// File: rtl/sn_stream_decoder.sv
// -----------------------------------------------------------------------------
// sn_stream_decoder
// Stochastic-to-binary decoder: counts ones over 2**WIN_LOG2 valid bits and
// presents the scaled estimate through a valid/ready output register.
// Optional feature: define SN_BIPOLAR_EN to register a two's-complement
// bipolar estimate alongside the unipolar one; otherwise est_bipolar is 0.
// Ports:
//   clk          in   posedge clock
//   rst_n        in   synchronous reset, active HIGH (1 = reset)
//   sn_bit       in   stochastic bit
//   sn_valid     in   sn_bit is sampled this cycle
//   win_clr      in   restart current window; output register untouched
//   est_data     out  unipolar estimate
//   est_bipolar  out  bipolar estimate (result - 2**(OUT_W-1))
//   est_valid    out  est_data/est_bipolar hold a result
//   est_ready    in   consumer accepts the result
//   ovr          out  sticky: a result was overwritten before acceptance
//
// Handshake: a result transfers in any cycle where est_valid && est_ready.
// While est_valid=1 and est_ready=0 the data is held, except when a new
// window ends, which overwrites it and sets ovr. A window ending in the
// same cycle as an acceptance simply loads the next result (no ovr).
// -----------------------------------------------------------------------------
module sn_stream_decoder
    import sn_pkg::*;
#(
    parameter int WIN_LOG2 = DEF_WIN_LOG2,
    parameter int OUT_W    = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sn_bit,
    input  logic             sn_valid,
    input  logic             win_clr,
    output logic [OUT_W-1:0] est_data,
    output logic [OUT_W-1:0] est_bipolar,
    output logic             est_valid,
    input  logic             est_ready,
    output logic             ovr
);

    logic              win_done;
    logic [WIN_LOG2:0] total;
    logic [OUT_W-1:0]  result;

    sn_out_state_e    state_q, state_d;
    logic [OUT_W-1:0] est_data_q, est_data_d;
    logic             ovr_q, ovr_d;

    sn_window_counter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_win (
        .clk        (clk),
        .rst_n      (rst_n),
        .sn_bit     (sn_bit),
        .sn_valid   (sn_valid),
        .win_clr    (win_clr),
        .win_done_o (win_done),
        .total_o    (total)
    );

    assign result = OUT_W'(sn_scale(32'(total), WIN_LOG2, OUT_W));

    always_comb begin
        state_d    = state_q;
        est_data_d = est_data_q;
        ovr_d      = ovr_q;
        if (win_done) begin
            est_data_d = result;
        end
        case (state_q)
            SN_EMPTY: begin
                if (win_done) state_d = SN_FULL;
            end
            SN_FULL: begin
                if (win_done) begin
                    if (!est_ready) ovr_d = 1'b1;
                end else if (est_ready) begin
                    state_d = SN_EMPTY;
                end
            end
            default: state_d = SN_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= SN_EMPTY;
            est_data_q <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            est_data_q <= est_data_d;
            ovr_q      <= ovr_d;
        end
    end

    assign est_valid = (state_q == SN_FULL);
    assign est_data  = est_data_q;
    assign ovr       = ovr_q;

`ifdef SN_BIPOLAR_EN
    logic [OUT_W-1:0] est_bipolar_q;

    // Flipping the MSB subtracts 2**(OUT_W-1): 2*P-1 in two's complement.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            est_bipolar_q <= '0;
        end else if (win_done) begin
            est_bipolar_q <= {~result[OUT_W-1], result[OUT_W-2:0]};
        end
    end

    assign est_bipolar = est_bipolar_q;
`else
    assign est_bipolar = '0;
`endif

endmodule

// File: tb/tb_sn_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_sn_stream_decoder
// Directed bench for sn_stream_decoder with default parameters (window 256,
// 8-bit estimate). Inputs change on the falling edge; outputs are checked on
// the falling edge after the rising edge that updates them.
// -----------------------------------------------------------------------------
module tb_sn_stream_decoder;

    logic       clk;
    logic       rst_n;
    logic       sn_bit;
    logic       sn_valid;
    logic       win_clr;
    logic [7:0] est_data;
    logic [7:0] est_bipolar;
    logic       est_valid;
    logic       est_ready;
    logic       ovr;

    int compared   = 0;
    int mismatched = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    sn_stream_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sn_bit      (sn_bit),
        .sn_valid    (sn_valid),
        .win_clr     (win_clr),
        .est_data    (est_data),
        .est_bipolar (est_bipolar),
        .est_valid   (est_valid),
        .est_ready   (est_ready),
        .ovr         (ovr)
    );

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        sn_valid = 1'b0;
        sn_bit   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        sn_valid = 1'b1;
        sn_bit   = b;
        @(negedge clk);
        sn_valid = 1'b0;
        sn_bit   = 1'b0;
    endtask

    task automatic drive_bits(input int n, input logic b);
        for (int i = 0; i < n; i++) drive_bit(b);
    endtask

    // Same as drive_bits but with a random idle cycle before about half the bits.
    task automatic drive_bits_gappy(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            drive_bit(b);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bipolar output model: result - 128 in two's complement, or 0 when the
    // feature is compiled out.
    function automatic logic [7:0] exp_bip(input logic [7:0] r);
`ifdef SN_BIPOLAR_EN
        exp_bip = r - 8'd128;
`else
        exp_bip = 8'h00;
`endif
    endfunction

    task automatic chk_result(input string tag, input logic [7:0] r);
        chk({tag, "_valid"}, {31'd0, est_valid}, 32'd1);
        chk({tag, "_data"},  {24'd0, est_data},  {24'd0, r});
        chk({tag, "_bip"},   {24'd0, est_bipolar}, {24'd0, exp_bip(r)});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b1;
        sn_bit    = 1'b0;
        sn_valid  = 1'b0;
        win_clr   = 1'b0;
        est_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_valid", {31'd0, est_valid}, 32'd0);
        chk("rst_data",  {24'd0, est_data},  32'd0);
        chk("rst_bip",   {24'd0, est_bipolar}, 32'd0);
        chk("rst_ovr",   {31'd0, ovr}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);

        // 1. all ones: saturated result one cycle after the 256th bit
        drive_bits(255, 1'b1);
        chk("ones_pre_valid", {31'd0, est_valid}, 32'd0);
        drive_bit(1'b1);
        chk_result("ones", 8'hFF);
        idle(1);
        chk("ones_accept_valid", {31'd0, est_valid}, 32'd0);
        chk("ones_hold_data", {24'd0, est_data}, 32'hFF);

        // 2. all zeros, then alternating 1/0 (128 ones)
        drive_bits(256, 1'b0);
        chk_result("zeros", 8'h00);
        for (int i = 0; i < 128; i++) begin
            drive_bit(1'b1);
            drive_bit(1'b0);
        end
        chk_result("alt", 8'h80);

        // 3. 64 ones then 192 zeros with random gaps
        drive_bits_gappy(64, 1'b1);
        drive_bits_gappy(191, 1'b0);
        idle(1);
        chk("gap_pre_valid", {31'd0, est_valid}, 32'd0);
        drive_bit(1'b0);
        chk_result("gap", 8'h40);
        idle(1);

        // 5. acceptance in the same cycle as a window end: no overrun
        est_ready = 1'b0;
        drive_bits(256, 1'b0);
        chk_result("same_a", 8'h00);
        drive_bits(32, 1'b1);
        drive_bits(223, 1'b0);
        chk("same_hold_data", {24'd0, est_data}, 32'h00);
        est_ready = 1'b1;
        drive_bit(1'b0);
        chk_result("same_b", 8'h20);
        chk("same_ovr", {31'd0, ovr}, 32'd0);
        idle(1);
        chk("same_accept_valid", {31'd0, est_valid}, 32'd0);

        // 4. consumer stalled across two windows: overwrite sets ovr
        est_ready = 1'b0;
        drive_bits(100, 1'b1);
        drive_bits(156, 1'b0);
        chk_result("ovr_a", 8'h64);
        chk("ovr_a_ovr", {31'd0, ovr}, 32'd0);
        drive_bits(200, 1'b1);
        chk("ovr_hold_data", {24'd0, est_data}, 32'h64);
        drive_bits(56, 1'b0);
        chk_result("ovr_b", 8'hC8);
        chk("ovr_b_ovr", {31'd0, ovr}, 32'd1);
        est_ready = 1'b1;
        idle(1);
        chk("ovr_accept_valid", {31'd0, est_valid}, 32'd0);
        chk("ovr_sticky", {31'd0, ovr}, 32'd1);

        // 6. win_clr at bit 100 with a valid one: bit dropped, window restarts
        drive_bits(100, 1'b1);
        win_clr = 1'b1;
        drive_bit(1'b1);
        win_clr = 1'b0;
        drive_bits(255, 1'b1);
        chk("clr_pre_valid", {31'd0, est_valid}, 32'd0);
        drive_bit(1'b1);
        chk_result("clr", 8'hFF);

        // reset mid-window with a pending result
        est_ready = 1'b0;
        drive_bits(50, 1'b1);
        rst_n = 1'b1;
        drive_bit(1'b1);
        rst_n = 1'b0;
        chk("mrst_valid", {31'd0, est_valid}, 32'd0);
        chk("mrst_data",  {24'd0, est_data},  32'd0);
        chk("mrst_bip",   {24'd0, est_bipolar}, 32'd0);
        chk("mrst_ovr",   {31'd0, ovr}, 32'd0);

        // the discarded partial window must not shorten the next one
        est_ready = 1'b1;
        drive_bits(128, 1'b1);
        drive_bits(127, 1'b0);
        chk("post_rst_pre_valid", {31'd0, est_valid}, 32'd0);
        drive_bit(1'b0);
        chk_result("post_rst", 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
